// File: rtl/ram_write_sequencer.sv
// Fixed-priority write sequencer for the 8-bit RAM: grants one requester, drives the
// source-mux selects and generates the RAM write enable/address for the programmed length.
module ram_write_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  ReqLayer,
  input  logic                  ReqFile,
  input  logic                  ReqDecomp,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [LEN_WIDTH-1:0]  Len,
  input  logic                  ValidIn,
  input  logic                  Abort,
  output logic                  GrantLayer,
  output logic                  GrantFile,
  output logic                  GrantDecomp,
  output logic                  Load,
  output logic                  Image,
  output logic                  Layer,
  output logic                  Ready,
  output logic                  RamWrite,
  output logic [ADDR_WIDTH-1:0] RamAddr,
  output logic                  Busy,
  output logic                  Done,
  output logic [1:0]            DbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            grant_q, grant_d;   // {layer, file, decomp}, one-hot or zero
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  ready;
  logic                  wr;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // A beat transfers in any cycle where ValidIn and Ready are both high; the mux
  // delivers the byte to the RAM in that same cycle, so RamWrite is their AND.
  assign ready = (state_q == XFER);
  assign wr    = ready & ValidIn;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (ReqLayer || ReqFile || ReqDecomp) begin
          if (ReqLayer)     grant_d = 3'b100;
          else if (ReqFile) grant_d = 3'b010;
          else              grant_d = 3'b001;
          addr_d  = BaseAddr;
          rem_d   = Len;
          state_d = (Len != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        if (wr) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = DONE;
        end
        // Abort still lets a same-cycle beat land before finishing.
        if (Abort) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  assign GrantLayer  = grant_q[2];
  assign GrantFile   = grant_q[1];
  assign GrantDecomp = grant_q[0];
  assign Layer       = grant_q[2];
  assign Load        = grant_q[1] | grant_q[0];
  assign Image       = grant_q[1];
  assign Ready       = ready;
  assign RamWrite    = wr;
  assign RamAddr     = addr_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = (state_q == DONE);
  assign DbgState    = state_q;

endmodule
